// File: rtl/ram_if.sv
// Bus bundle for the single-port flip-flop RAM: write enable, address, write data and read data.
interface ram_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4
);
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] din;
    logic [DATA_WIDTH-1:0] dout;

    modport master (output we, output addr, output din, input dout);
    modport slave  (input we, input addr, input din, output dout);
endinterface

// File: rtl/ram.sv
// Single-port synchronous RAM built from flip-flops: synchronous write, registered
// write-first read, asynchronous active-low reset clearing array and output.
module ram #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic  clk,
    input  logic  rst_n,
    ram_if.slave  bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] dout_q;

    // Every active edge refreshes dout: from din on a write, from the array on a read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            dout_q <= '0;
        end else if (bus.we) begin
            mem[bus.addr] <= bus.din;
            dout_q        <= bus.din;
        end else begin
            dout_q <= mem[bus.addr];
        end
    end

    assign bus.dout = dout_q;
endmodule

// File: tb/tb_ram.sv
// Self-checking bench for ram: directed scenarios plus randomized traffic against a byte-array model.
module tb_ram;
    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 16;

    logic clk;
    logic rst_n;

    ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int errors;

    logic [DW-1:0] model [DEPTH];
    logic [DW-1:0] exp_dout;

    task automatic model_clear();
        for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;
        exp_dout = '0;
    endtask

    // One access: drive at negedge, let one rising edge happen, check 1 time unit later.
    task automatic access(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input string name);
        @(negedge clk);
        bus.we   = w;
        bus.addr = a;
        bus.din  = d;
        @(posedge clk);
        if (w) begin
            model[a] = d;
            exp_dout = d;
        end else begin
            exp_dout = model[a];
        end
        #1;
        checks++;
        if (bus.dout !== exp_dout) begin
            errors++;
            $display("FAIL %s: addr=%0d we=%0b dout=%h expected=%h", name, a, w, bus.dout, exp_dout);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < int'(DEPTH); i++) begin
            access(1'b0, AW'(i), 8'h00, "reset_read");
            checks++;
            if (bus.dout !== 8'h00) begin
                errors++;
                $display("FAIL reset_zero: addr=%0d dout=%h expected=00", i, bus.dout);
            end
        end
    endtask

    task automatic test_write_read();
        access(1'b1, 4'd3, 8'hAA, "wr3");
        access(1'b1, 4'd5, 8'h55, "wr5");
        access(1'b0, 4'd3, 8'h00, "rd3");
        checks++;
        if (bus.dout !== 8'hAA) begin
            errors++;
            $display("FAIL rd3_const: dout=%h expected=aa", bus.dout);
        end
        access(1'b0, 4'd5, 8'h00, "rd5");
        checks++;
        if (bus.dout !== 8'h55) begin
            errors++;
            $display("FAIL rd5_const: dout=%h expected=55", bus.dout);
        end
    endtask

    task automatic test_write_first();
        access(1'b1, 4'd7, 8'h3C, "wf_3c");
        checks++;
        if (bus.dout !== 8'h3C) begin
            errors++;
            $display("FAIL write_first: dout=%h expected=3c", bus.dout);
        end
        // dout must hold between edges
        #3;
        checks++;
        if (bus.dout !== 8'h3C) begin
            errors++;
            $display("FAIL hold: dout=%h expected=3c", bus.dout);
        end
        access(1'b1, 4'd7, 8'hC3, "wf_c3");
        access(1'b0, 4'd7, 8'h00, "last_wins");
        checks++;
        if (bus.dout !== 8'hC3) begin
            errors++;
            $display("FAIL last_wins_const: dout=%h expected=c3", bus.dout);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < int'(DEPTH); i++) access(1'b1, AW'(i), DW'(8'hA0 + i), "fill_wr");
        for (int i = 0; i < int'(DEPTH); i++) begin
            access(1'b0, AW'(i), 8'h00, "fill_rd");
            checks++;
            if (bus.dout !== DW'(8'hA0 + i)) begin
                errors++;
                $display("FAIL fill_const: addr=%0d dout=%h expected=%h", i, bus.dout, DW'(8'hA0 + i));
            end
        end
        access(1'b1, 4'd0, 8'h5A, "edge0_wr");
        access(1'b0, 4'd15, 8'h00, "edge15_rd");
        checks++;
        if (bus.dout !== 8'hAF) begin
            errors++;
            $display("FAIL addr_independent: dout=%h expected=af", bus.dout);
        end
    endtask

    task automatic test_async_reset();
        access(1'b1, 4'd9, 8'hFF, "pre_rst_wr");
        @(negedge clk);
        bus.we = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        model_clear();
        checks++;
        if (bus.dout !== 8'h00) begin
            errors++;
            $display("FAIL async_clear: dout=%h expected=00", bus.dout);
        end
        #1 rst_n = 1'b1;
        access(1'b0, 4'd9, 8'h00, "post_rst_rd9");
        access(1'b0, 4'd0, 8'h00, "post_rst_rd0");
    endtask

    task automatic test_reset_hold();
        access(1'b1, 4'd2, 8'h77, "pre_hold_wr");
        @(negedge clk);
        rst_n    = 1'b0;
        bus.we   = 1'b1;
        bus.addr = 4'd2;
        bus.din  = 8'h11;
        model_clear();
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.dout !== 8'h00) begin
                errors++;
                $display("FAIL reset_hold_dout: edge=%0d dout=%h expected=00", k, bus.dout);
            end
        end
        @(negedge clk);
        bus.we = 1'b0;
        rst_n  = 1'b1;
        access(1'b0, 4'd2, 8'h00, "hold_rd2");
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            access(1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)),
                   DW'($urandom), "random");
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] vals [DEPTH];
        for (int i = 0; i < int'(DEPTH); i++) begin
            vals[i] = DW'($urandom);
            access(1'b1, AW'(DEPTH - 1 - i), vals[i], "b2b_wr");
        end
        for (int i = 0; i < int'(DEPTH); i++) begin
            access(1'b0, AW'(DEPTH - 1 - i), 8'h00, "b2b_rd");
            checks++;
            if (bus.dout !== vals[i]) begin
                errors++;
                $display("FAIL b2b_retained: addr=%0d dout=%h expected=%h", DEPTH - 1 - i, bus.dout, vals[i]);
            end
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        bus.we   = 1'b0;
        bus.addr = '0;
        bus.din  = '0;
        model_clear();
        #2;
        checks++;
        if (bus.dout !== 8'h00) begin
            errors++;
            $display("FAIL reset_dout: dout=%h expected=00", bus.dout);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        test_reset();
        test_write_read();
        test_write_first();
        test_fill();
        test_async_reset();
        test_reset_hold();
        test_back_to_back();
        test_random();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ram.md
Name: ram

Overview:
- Single-port synchronous RAM, 16 words x 8 bits by default, built from flip-flops.
- Used as a small scratch or register-file store inside a single clock domain.
- Synchronous write, registered read, write-first on read-during-write.
- Asynchronous active-low reset clears the entire array and the output register.

Parameters:
- DATA_WIDTH, 8, width of each word and of din/dout.
- ADDR_WIDTH, 4, address width; DEPTH = 2**ADDR_WIDTH words (16 by default).

Ports:
- clk  input  1  system clock; all non-reset activity on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- we  input  1  write enable; 1 = write din to addr at the clock edge, 0 = read.
- addr  input  ADDR_WIDTH  word address for both read and write.
- din  input  DATA_WIDTH  write data.
- dout  output  DATA_WIDTH  registered read data.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Clock and reset ports are named clk and rst_n.
- Reset assertion (rst_n falls):
  - Immediately, with no clock needed, every memory word = 0 and dout = 0.
  - Held while rst_n = 0; clock edges during reset are ignored and writes are dropped.
- Reset release: the first rising clk edge with rst_n = 1 is the first active edge.
- Write (we = 1 at a rising edge):
  - mem[addr] <= din.
  - Write-first: dout <= din in the same edge.
- Read (we = 0 at a rising edge):
  - dout <= mem[addr].
  - Read latency is 1 cycle: data is visible after the edge that samples addr.
- dout holds its value between edges.
- No hold/enable state: every active edge updates dout from either din or mem.
- Full address range 0..DEPTH-1 is valid; no out-of-range case exists, and there is no wrap logic beyond the natural address width.
- Back-to-back writes to different addresses on consecutive edges are all retained.
- Back-to-back writes to the same address: the last write wins.
- Reset mid-operation:
  - Asserting rst_n during an access aborts it.
  - All contents and dout go to 0 asynchronously.
  - After release, any address reads 0 until written.
- X-free: all storage and dout have defined values after reset.
- No read-enable and no byte enables.

Test Plan:
1. Reset, then read each of addresses 0..15 -> dout = 8'h00 one cycle after each address is sampled.
2. Write 8'hAA to addr 3, then 8'h55 to addr 5. Read addr 3 -> dout = 8'hAA after one edge; read addr 5 -> dout = 8'h55.
3. Write 8'h3C to addr 7 -> dout = 8'h3C at the same edge (write-first). Write 8'hC3 to addr 7, then read -> 8'hC3 (last write wins).
4. Write 8'hA0+i to every address i = 0..15, then read all back -> each returns 8'hA0+i. Confirm addr 0 and addr 15 are independent.
5. Write 8'hFF to addr 9, pulse rst_n low between edges -> dout = 0 without a clock edge. After release, read addr 9 -> 8'h00.
6. Hold rst_n low with we = 1, addr 2, din 8'h11 across several edges. Release, then read addr 2 -> 8'h00 (writes during reset are ignored).
